// File: rtl/pc_gen_if.sv
// Fetch-PC bus between pc_gen (master) and the predictor/IF1/EX side (slave).
// Carries adef_o only when PCGEN_ALIGN_CHK_EN is defined.
interface pc_gen_if #(
    parameter int unsigned PC_W = 32
);
    logic            if1_ready;
    logic            bp_answ;
    logic [PC_W-1:0] bp_target;
    logic            bp_answ_bht;
    logic            bp_answ_ghr;
    logic            ex_redirect;
    logic [PC_W-1:0] ex_redirect_pc;
    logic            exc_redirect;
    logic [PC_W-1:0] exc_pc;
    logic            idle_req;
    logic [PC_W-1:0] pc_o;
    logic            pc_valid_o;
    logic            flush_o;
    logic            pred_taken_o;
    logic            pred_bht_o;
    logic            pred_ghr_o;
    logic [PC_W-1:0] pred_target_o;
`ifdef PCGEN_ALIGN_CHK_EN
    logic            adef_o;
`endif

    modport master (
        input  if1_ready, bp_answ, bp_target, bp_answ_bht, bp_answ_ghr,
               ex_redirect, ex_redirect_pc, exc_redirect, exc_pc, idle_req,
        output pc_o, pc_valid_o, flush_o, pred_taken_o, pred_bht_o,
               pred_ghr_o, pred_target_o
`ifdef PCGEN_ALIGN_CHK_EN
        , output adef_o
`endif
    );

    modport slave (
        output if1_ready, bp_answ, bp_target, bp_answ_bht, bp_answ_ghr,
               ex_redirect, ex_redirect_pc, exc_redirect, exc_pc, idle_req,
        input  pc_o, pc_valid_o, flush_o, pred_taken_o, pred_bht_o,
               pred_ghr_o, pred_target_o
`ifdef PCGEN_ALIGN_CHK_EN
        , input adef_o
`endif
    );
endinterface

// File: rtl/pc_gen.sv
// IF0 next-PC generator: exception/ertn > EX mispredict > predictor > PC+4, with stall hold and idle parking.
// Optional misaligned-fetch detection (adef_o) under macro PCGEN_ALIGN_CHK_EN.
module pc_gen #(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h1c00_0000)
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.master bus
);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_IDLE} state_t;

    state_t          r_state, w_state_nx;
    logic [PC_W-1:0] r_pc, w_pc_nx, w_pc_inc;
    logic            r_pc_valid, w_pc_valid_nx;
    logic            r_flush, w_flush_nx;
    logic            r_pred_taken, w_pred_taken_nx;
    logic            r_pred_bht, w_pred_bht_nx;
    logic            r_pred_ghr, w_pred_ghr_nx;
    logic [PC_W-1:0] r_pred_target, w_pred_target_nx;
    logic            w_exc_take, w_ex_take, w_accept, w_hold_pc;

`ifdef PCGEN_ALIGN_CHK_EN
    logic            r_adef;
    assign w_hold_pc = (r_pc[1:0] != 2'b00);
`else
    assign w_hold_pc = 1'b0;
`endif

    // exc_redirect is honoured in RUN and IDLE; ex_redirect only in RUN and loses to exc
    assign w_exc_take    = bus.exc_redirect && (r_state != S_BOOT);
    assign w_ex_take     = bus.ex_redirect && (r_state == S_RUN) && !bus.exc_redirect;
    assign w_accept      = r_pc_valid && bus.if1_ready && !w_hold_pc;
    assign w_pc_inc      = r_pc + PC_W'(4);
    assign w_pc_valid_nx = (w_state_nx == S_RUN);

    always_comb begin
        w_state_nx       = r_state;
        w_pc_nx          = r_pc;
        w_flush_nx       = 1'b0;
        w_pred_taken_nx  = r_pred_taken;
        w_pred_bht_nx    = r_pred_bht;
        w_pred_ghr_nx    = r_pred_ghr;
        w_pred_target_nx = r_pred_target;

        case (r_state)
            S_BOOT:  w_state_nx = S_RUN;
            S_RUN:   if (bus.idle_req && !bus.exc_redirect) w_state_nx = S_IDLE;
            S_IDLE:  if (bus.exc_redirect) w_state_nx = S_RUN;
            default: w_state_nx = S_BOOT;
        endcase

        if (w_exc_take) begin
            w_pc_nx         = bus.exc_pc;
            w_flush_nx      = 1'b1;
            w_pred_taken_nx = 1'b0;
        end else if (w_ex_take) begin
            w_pc_nx         = bus.ex_redirect_pc;
            w_flush_nx      = 1'b1;
            w_pred_taken_nx = 1'b0;
        end else if (w_accept) begin
            w_pc_nx          = bus.bp_answ ? bus.bp_target : w_pc_inc;
            w_pred_taken_nx  = bus.bp_answ;
            w_pred_bht_nx    = bus.bp_answ_bht;
            w_pred_ghr_nx    = bus.bp_answ_ghr;
            w_pred_target_nx = bus.bp_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_BOOT;
            r_pc          <= RESET_PC;
            r_pc_valid    <= 1'b0;
            r_flush       <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_bht    <= 1'b0;
            r_pred_ghr    <= 1'b0;
            r_pred_target <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_pc          <= w_pc_nx;
            r_pc_valid    <= w_pc_valid_nx;
            r_flush       <= w_flush_nx;
            r_pred_taken  <= w_pred_taken_nx;
            r_pred_bht    <= w_pred_bht_nx;
            r_pred_ghr    <= w_pred_ghr_nx;
            r_pred_target <= w_pred_target_nx;
        end
    end

`ifdef PCGEN_ALIGN_CHK_EN
    // Flag tracks the registered PC so it is high exactly while a misaligned PC is live
    always_ff @(posedge clk) begin
        if (rst) r_adef <= 1'b0;
        else     r_adef <= w_pc_valid_nx && (w_pc_nx[1:0] != 2'b00);
    end
    assign bus.adef_o = r_adef;
`endif

    assign bus.pc_o          = r_pc;
    assign bus.pc_valid_o    = r_pc_valid;
    assign bus.flush_o       = r_flush;
    assign bus.pred_taken_o  = r_pred_taken;
    assign bus.pred_bht_o    = r_pred_bht;
    assign bus.pred_ghr_o    = r_pred_ghr;
    assign bus.pred_target_o = r_pred_target;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; adds an alignment scenario when PCGEN_ALIGN_CHK_EN is defined.
module tb_pc_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pc_gen_if #(.PC_W(32)) bus ();

    pc_gen #(.PC_W(32), .RESET_PC(32'h1c00_0000)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pc(input string name, input logic [31:0] exp);
        n_checks++;
        if (bus.pc_o !== exp) begin
            n_fail++;
            $display("FAIL %s pc_o got %h want %h", name, bus.pc_o, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %b want %b", name, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.if1_ready      = 1'b0;
        bus.bp_answ        = 1'b0;
        bus.bp_target      = '0;
        bus.bp_answ_bht    = 1'b0;
        bus.bp_answ_ghr    = 1'b0;
        bus.ex_redirect    = 1'b0;
        bus.ex_redirect_pc = '0;
        bus.exc_redirect   = 1'b0;
        bus.exc_pc         = '0;
        bus.idle_req       = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk_pc("reset", 32'h1c00_0000);
        chk_bit("reset valid", bus.pc_valid_o, 1'b0);
        chk_bit("reset flush", bus.flush_o, 1'b0);
        chk_bit("reset pred_taken", bus.pred_taken_o, 1'b0);
        n_checks++;
        if (bus.pred_target_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset pred_target got %h want 0", bus.pred_target_o);
        end
`ifdef PCGEN_ALIGN_CHK_EN
        chk_bit("reset adef", bus.adef_o, 1'b0);
`endif
        rst = 1'b0;
        bus.if1_ready = 1'b1;
        tick();
        chk_pc("boot", 32'h1c00_0000);
        chk_bit("boot->run valid", bus.pc_valid_o, 1'b1);
    endtask

    task automatic test_sequential();
        tick();
        chk_pc("seq +4", 32'h1c00_0004);
        tick();
        chk_pc("seq +8", 32'h1c00_0008);
    endtask

    task automatic test_predict();
        bus.bp_answ = 1'b1; bus.bp_target = 32'h1c00_0100;
        bus.bp_answ_bht = 1'b1; bus.bp_answ_ghr = 1'b0;
        tick();
        chk_pc("pred target", 32'h1c00_0100);
        chk_bit("pred taken", bus.pred_taken_o, 1'b1);
        chk_bit("pred bht", bus.pred_bht_o, 1'b1);
        n_checks++;
        if (bus.pred_target_o !== 32'h1c00_0100) begin
            n_fail++;
            $display("FAIL pred_target got %h want 1c000100", bus.pred_target_o);
        end
        bus.bp_answ = 1'b0; bus.bp_target = '0;
        bus.bp_answ_bht = 1'b0; bus.bp_answ_ghr = 1'b1;
        tick();
        chk_pc("pred not taken", 32'h1c00_0104);
        chk_bit("pred taken cleared", bus.pred_taken_o, 1'b0);
        chk_bit("pred ghr", bus.pred_ghr_o, 1'b1);
        bus.bp_answ_ghr = 1'b0;
    endtask

    task automatic test_stall();
        bus.if1_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_pc("stall hold", 32'h1c00_0104);
        end
        chk_bit("stall pred ghr hold", bus.pred_ghr_o, 1'b1);
        bus.ex_redirect = 1'b1; bus.ex_redirect_pc = 32'h1c00_0200;
        tick();
        chk_pc("ex redirect in stall", 32'h1c00_0200);
        chk_bit("ex redirect flush", bus.flush_o, 1'b1);
        bus.ex_redirect = 1'b0;
        tick();
        chk_bit("flush one cycle", bus.flush_o, 1'b0);
        chk_pc("post redirect hold", 32'h1c00_0200);
        bus.if1_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        bus.bp_answ = 1'b1; bus.bp_target = 32'h1c00_0500;
        tick();
        chk_pc("b2b predicted", 32'h1c00_0500);
        chk_bit("b2b pred taken", bus.pred_taken_o, 1'b1);
        bus.bp_answ = 1'b0; bus.bp_target = '0;
        bus.exc_redirect = 1'b1; bus.exc_pc = 32'h1c00_8000;
        bus.ex_redirect = 1'b1; bus.ex_redirect_pc = 32'h1c00_0300;
        tick();
        chk_pc("exc beats ex", 32'h1c00_8000);
        chk_bit("dual redirect flush", bus.flush_o, 1'b1);
        chk_bit("redirect clears pred_taken", bus.pred_taken_o, 1'b0);
        n_checks++;
        if (bus.pred_target_o !== 32'h1c00_0500) begin
            n_fail++;
            $display("FAIL redirect pred_target hold got %h want 1c000500", bus.pred_target_o);
        end
        bus.exc_redirect = 1'b0; bus.ex_redirect = 1'b0;
        tick();
        chk_pc("after dual redirect", 32'h1c00_8004);
        chk_bit("after dual flush", bus.flush_o, 1'b0);
    endtask

    task automatic test_idle();
        bus.if1_ready = 1'b0;
        bus.idle_req  = 1'b1;
        tick();
        chk_bit("idle valid", bus.pc_valid_o, 1'b0);
        bus.idle_req = 1'b0;
        bus.if1_ready = 1'b1;
        bus.ex_redirect = 1'b1; bus.ex_redirect_pc = 32'h1c00_0300;
        tick();
        chk_pc("idle ignores ex", 32'h1c00_8004);
        chk_bit("idle ignores ex flush", bus.flush_o, 1'b0);
        bus.ex_redirect = 1'b0;
        tick();
        chk_pc("idle frozen", 32'h1c00_8004);
        chk_bit("idle still invalid", bus.pc_valid_o, 1'b0);
        bus.exc_redirect = 1'b1; bus.exc_pc = 32'h1c00_8000;
        tick();
        chk_pc("idle wake", 32'h1c00_8000);
        chk_bit("wake valid", bus.pc_valid_o, 1'b1);
        chk_bit("wake flush", bus.flush_o, 1'b1);
        bus.exc_redirect = 1'b0;
        bus.if1_ready = 1'b0;
        bus.idle_req  = 1'b1;
        tick();
        bus.idle_req = 1'b0;
        chk_bit("idle again", bus.pc_valid_o, 1'b0);
        rst = 1'b1;
        tick();
        chk_pc("reset in idle", 32'h1c00_0000);
        chk_bit("reset in idle valid", bus.pc_valid_o, 1'b0);
        rst = 1'b0;
        bus.if1_ready = 1'b1;
        tick();
        chk_bit("reboot valid", bus.pc_valid_o, 1'b1);
        chk_pc("reboot pc", 32'h1c00_0000);
    endtask

    task automatic test_idle_exc();
        bus.idle_req = 1'b1;
        bus.exc_redirect = 1'b1; bus.exc_pc = 32'h1c00_9000;
        tick();
        chk_pc("idle+exc pc", 32'h1c00_9000);
        chk_bit("idle+exc stays run", bus.pc_valid_o, 1'b1);
        bus.idle_req = 1'b0; bus.exc_redirect = 1'b0;
        tick();
        chk_pc("idle+exc next", 32'h1c00_9004);
    endtask

    task automatic test_wrap();
        bus.ex_redirect = 1'b1; bus.ex_redirect_pc = 32'hffff_fffc;
        tick();
        chk_pc("wrap start", 32'hffff_fffc);
        bus.ex_redirect = 1'b0;
        tick();
        chk_pc("wrap to zero", 32'h0000_0000);
        chk_bit("wrap valid", bus.pc_valid_o, 1'b1);
    endtask

`ifdef PCGEN_ALIGN_CHK_EN
    task automatic test_align();
        bus.ex_redirect = 1'b1; bus.ex_redirect_pc = 32'h1c00_0102;
        tick();
        bus.ex_redirect = 1'b0;
        chk_pc("misaligned pc", 32'h1c00_0102);
        chk_bit("adef set", bus.adef_o, 1'b1);
        bus.bp_answ = 1'b1; bus.bp_target = 32'h1c00_0400;
        tick();
        tick();
        chk_pc("misaligned hold", 32'h1c00_0102);
        chk_bit("adef held", bus.adef_o, 1'b1);
        bus.bp_answ = 1'b0; bus.bp_target = '0;
        bus.ex_redirect = 1'b1; bus.ex_redirect_pc = 32'h1c00_0200;
        tick();
        bus.ex_redirect = 1'b0;
        chk_pc("align recover", 32'h1c00_0200);
        chk_bit("adef clear", bus.adef_o, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_predict();
        test_stall();
        test_back_to_back();
        test_idle();
        test_idle_exc();
        test_wrap();
`ifdef PCGEN_ALIGN_CHK_EN
        test_align();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
